// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter in front of the 512-byte data memory.
// Port A (pipeline MEM stage) has priority. Port B (debug/DMA) is forced
// through after MAX_WAIT consecutive denied cycles. Illegal accesses are
// granted and consumed but never reach memory, and they return an error pulse.
//
// Handshake: a requester raises x_req with x_we/x_addr/x_wdata/x_type and
// holds them stable until x_gnt is seen high in the same cycle. x_gnt is
// combinational, so each cycle with x_req && x_gnt transfers one request.
// Exactly one x_rvalid pulse follows on the next cycle, carrying x_rdata
// and x_err. There is no backpressure on the response side.
module dm_arbiter #(
    parameter int MAX_WAIT       = 4,
    parameter bit ALLOW_MISALIGN = 1'b0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [8:0]  a_addr,
    input  logic [31:0] a_wdata,
    input  logic [2:0]  a_type,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    output logic        a_err,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [8:0]  b_addr,
    input  logic [31:0] b_wdata,
    input  logic [2:0]  b_type,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic        b_err,
    output logic        dm_we,
    output logic [8:0]  dm_addr,
    output logic [31:0] dm_din,
    output logic [2:0]  dm_type,
    input  logic [31:0] dm_dout
);

    localparam int            WW    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] MAX_W = WW'(MAX_WAIT);

    // DMType encodings shared with dm
    localparam logic [2:0] DM_WORD     = 3'b000;
    localparam logic [2:0] DM_HALF     = 3'b001;
    localparam logic [2:0] DM_HALF_U   = 3'b010;
    localparam logic [2:0] DM_BYTE     = 3'b011;
    localparam logic [2:0] DM_BYTE_U   = 3'b100;

    logic [WW-1:0] wait_cnt;
    logic          b_win;
    logic          any_gnt;
    logic          sel_we;
    logic [8:0]    sel_addr;
    logic [31:0]   sel_wdata;
    logic [2:0]    sel_type;
    logic          sel_legal;
    logic [31:0]   rdata_next;

    // Pick the winner: A by default, B when alone or when its wait has run out
    always_comb begin
        b_win   = b_req && (!a_req || (wait_cnt == MAX_W));
        a_gnt   = a_req && !b_win;
        b_gnt   = b_win;
        any_gnt = a_req || b_req;
    end

    // Route the winner's request fields; all zero when nobody asks
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = 9'd0;
        sel_wdata = 32'd0;
        sel_type  = 3'd0;
        if (b_win) begin
            sel_we    = b_we;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
            sel_type  = b_type;
        end else if (a_req) begin
            sel_we    = a_we;
            sel_addr  = a_addr;
            sel_wdata = a_wdata;
            sel_type  = a_type;
        end
    end

    // Legality of the selected access: encoding, store type, bounds, alignment
    always_comb begin
        sel_legal = 1'b1;
        case (sel_type)
            DM_WORD: begin
                if (sel_addr > 9'd508) sel_legal = 1'b0;
                if (!ALLOW_MISALIGN && (sel_addr[1:0] != 2'b00)) sel_legal = 1'b0;
            end
            DM_HALF, DM_HALF_U: begin
                if (sel_addr > 9'd510) sel_legal = 1'b0;
                if (!ALLOW_MISALIGN && sel_addr[0]) sel_legal = 1'b0;
            end
            DM_BYTE, DM_BYTE_U: begin
                sel_legal = 1'b1;
            end
            default: sel_legal = 1'b0;
        endcase
        // unsigned variants only make sense for loads
        if (sel_we && ((sel_type == DM_HALF_U) || (sel_type == DM_BYTE_U))) begin
            sel_legal = 1'b0;
        end
    end

    // Drive memory only for a legal grant; an illegal access sees all zeros
    always_comb begin
        dm_we   = 1'b0;
        dm_addr = 9'd0;
        dm_din  = 32'd0;
        dm_type = 3'd0;
        if (any_gnt && sel_legal) begin
            dm_we   = sel_we;
            dm_addr = sel_addr;
            dm_din  = sel_wdata;
            dm_type = sel_type;
        end
    end

    // Read data is only meaningful for a legal load
    always_comb begin
        rdata_next = (sel_legal && !sel_we) ? dm_dout : 32'd0;
    end

    // Port A response pipe: one pulse per grant
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_rvalid <= 1'b0;
            a_rdata  <= 32'd0;
            a_err    <= 1'b0;
        end else begin
            a_rvalid <= a_gnt;
            a_rdata  <= a_gnt ? rdata_next : 32'd0;
            a_err    <= a_gnt && !sel_legal;
        end
    end

    // Port B response pipe: one pulse per grant
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            b_rvalid <= 1'b0;
            b_rdata  <= 32'd0;
            b_err    <= 1'b0;
        end else begin
            b_rvalid <= b_gnt;
            b_rdata  <= b_gnt ? rdata_next : 32'd0;
            b_err    <= b_gnt && !sel_legal;
        end
    end

    // Count consecutive denied B cycles, saturating, cleared on grant or idle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt <= '0;
        end else if (b_req && !b_gnt) begin
            wait_cnt <= (wait_cnt == MAX_W) ? MAX_W : wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter in front of the byte-addressed data memory `dm` (512 bytes, 9-bit address).
- Shares the memory between the pipeline MEM stage (port A) and a debug/DMA port (port B).
- Grants at most one access per cycle and forwards the granted request to `dm`.
- Returns read data one cycle after grant and rejects illegal accesses with an error pulse; a rejected access never touches memory.

Parameters:
- MAX_WAIT, 4: consecutive denied cycles of port B before B is forced to win one arbitration.
- ALLOW_MISALIGN, 0: 1 allows non-naturally-aligned halfword/word accesses; 0 rejects them.

Ports:
- clk  in  1  system clock, all state on posedge.
- rstn  in  1  asynchronous active-low reset.
- a_req  in  1  port A request, held until a_gnt.
- a_we  in  1  port A write enable.
- a_addr  in  9  port A byte address.
- a_wdata  in  32  port A store data.
- a_type  in  3  port A DMType (dm_word/dm_halfword/dm_byte/dm_halfword_unsigned/dm_byte_unsigned from ctrl_encode_def.v).
- a_gnt  out  1  port A request accepted this cycle (combinational).
- a_rvalid  out  1  port A read data / error valid (registered).
- a_rdata  out  32  port A read data (registered).
- a_err  out  1  port A accepted request was illegal (registered, with a_rvalid).
- b_req, b_we, b_addr, b_wdata, b_type, b_gnt, b_rvalid, b_rdata, b_err: same as port A, for port B.
- dm_we  out  1  to dm DMWr.
- dm_addr  out  9  to dm addr.
- dm_din  out  32  to dm din.
- dm_type  out  3  to dm DMType.
- dm_dout  in  32  from dm dout (combinational read).

Behaviour:
- Reset (rstn low, async): a_rvalid, b_rvalid, a_err, b_err = 0; a_rdata, b_rdata = 0; wait_cnt = 0. Combinational outputs with req low: a_gnt = b_gnt = 0, dm_we = 0, dm_addr = 0, dm_din = 0, dm_type = 0.
- Arbitration (combinational each cycle):
  - Only A requesting: A wins.
  - Only B requesting: B wins.
  - Both requesting: A wins unless wait_cnt == MAX_WAIT, in which case B wins.
- Grant: winner's x_gnt = 1, loser's = 0.
- wait_cnt (clog2(MAX_WAIT+1) bits):
  - Increments when b_req = 1 and b_gnt = 0.
  - Clears when b_gnt = 1 or b_req = 0.
  - Saturates at MAX_WAIT.
- Legality check on the winner:
  - illegal if dm_type is not one of the five encodings;
  - illegal if a write uses dm_halfword_unsigned or dm_byte_unsigned;
  - illegal if addr + size - 1 > 511 (word: addr > 508; halfword: addr > 510);
  - if ALLOW_MISALIGN = 0, illegal if a word has addr[1:0] != 0 or a halfword has addr[0] != 0.
- Legal grant: dm_addr/dm_din/dm_type/dm_we driven from the winner in the same cycle. Writes commit at the same posedge (dm latency 0).
- Illegal grant: dm_we forced 0 and dm_type forced 0 (dm outputs 0). The request still receives a grant, so it is consumed.
- Response, registered on the posedge ending the grant cycle:
  - x_rvalid = 1 for one cycle for every granted request, read or write.
  - x_rdata = dm_dout for a legal read, else 0.
  - x_err = 1 if illegal.
- Throughput: one grant per cycle total. Back-to-back grants to the same port are allowed. Each port's response pipe is independent.
- Requester rule: x_req/x_addr/x_we/x_wdata/x_type stable until x_gnt. Arbiter holds no request state; a dropped req is simply not serviced.
- Simultaneous same-address: the loser is serviced in a later cycle and observes the winner's write (write-first ordering by grant order).
- Reset mid-operation: pending rvalid/err are cleared; no retry; memory contents are untouched by the arbiter.

Test Plan:
- Reset then A read, addr 0x010, word, memory holds 0xDEADBEEF → a_gnt same cycle; next cycle a_rvalid = 1, a_rdata = 0xDEADBEEF, a_err = 0.
- A write byte 0x5A to 0x003, then B read byte_unsigned at 0x003 → b_rdata = 0x0000005A. With byte (signed) → 0x0000005A. After write 0xA5, signed read → 0xFFFFFFA5.
- A and B both request continuously, MAX_WAIT = 4 → grant pattern A,A,A,A,B repeating; wait_cnt returns to 0 after each B grant.
- Illegal accesses → x_rvalid = 1, x_err = 1, rdata = 0, dm_we stays 0, memory unchanged. Covers word at 0x1FD, halfword at 0x003 with ALLOW_MISALIGN = 0, and a store with dm_byte_unsigned.
- ALLOW_MISALIGN = 1: word write 0x11223344 at 0x005, then word read → 0x11223344.
- Assert rstn low while a_rvalid is high → a_rvalid/a_rdata immediately 0 (async), wait_cnt 0; the first arbitration after release gives A priority.
